// File: rtl/arith_issue_q.sv
// arith_issue_q: queued 8-bit arithmetic stage (add/sub/mul/div/mod) with a registered, back-pressurable result
//   clk, reset (async, active-high)
//   in_valid/in_ready, in_op/in_a/in_b      : request push into the FIFO
//   out_valid/out_ready, out_res/out_dz/out_ill : registered result handshake
//   count                                   : FIFO occupancy
module arith_issue_q #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_res,
    output logic                       out_dz,
    output logic                       out_ill,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [3:0]        r_op [DEPTH];
    logic [WIDTH-1:0]  r_a  [DEPTH];
    logic [WIDTH-1:0]  r_b  [DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_count;
    logic              r_valid, r_dz, r_ill;
    logic [WIDTH-1:0]  r_res;

    logic              w_push, w_load, w_bz;
    logic [3:0]        w_op;
    logic [WIDTH-1:0]  w_ha, w_hb, w_bnz, w_res;
    logic              w_dz, w_ill;
    logic signed [WIDTH:0] w_sa, w_sb;

    assign in_ready  = r_count != CW'(DEPTH);
    assign w_push    = in_valid && in_ready;
    assign w_load    = (r_count != '0) && (!r_valid || out_ready);
    assign out_valid = r_valid;
    assign out_res   = r_res;
    assign out_dz    = r_dz;
    assign out_ill   = r_ill;
    assign count     = r_count;

    assign w_op  = r_op[r_rp];
    assign w_ha  = r_a[r_rp];
    assign w_hb  = r_b[r_rp];
    assign w_bz  = w_hb == '0;
    // Divisor forced to 1 on zero so the dividers never see b==0; the result is overridden anyway.
    assign w_bnz = w_bz ? WIDTH'(1) : w_hb;
    // One extra bit makes most-negative / -1 representable; truncation then wraps it back.
    assign w_sa  = {w_ha[WIDTH-1], w_ha};
    assign w_sb  = {w_bnz[WIDTH-1], w_bnz};

    always_comb begin
        w_res = '0;
        w_dz  = 1'b0;
        w_ill = 1'b0;
        case (w_op)
            4'd0, 4'd1: w_res = w_ha + w_hb;
            4'd2, 4'd3: w_res = w_ha - w_hb;
            4'd4, 4'd5: w_res = w_ha * w_hb;
            4'd6: begin
                w_dz  = w_bz;
                w_res = w_bz ? '1 : w_ha / w_bnz;
            end
            4'd7: begin
                w_dz  = w_bz;
                w_res = w_bz ? '1 : WIDTH'(w_sa / w_sb);
            end
            4'd8: begin
                w_dz  = w_bz;
                w_res = w_bz ? w_ha : w_ha % w_bnz;
            end
            4'd9: begin
                w_dz  = w_bz;
                w_res = w_bz ? w_ha : WIDTH'(w_sa % w_sb);
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i] <= '0;
                r_a[i]  <= '0;
                r_b[i]  <= '0;
            end
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_dz    <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            if (w_push) begin
                r_op[r_wp] <= in_op;
                r_a[r_wp]  <= in_a;
                r_b[r_wp]  <= in_b;
                r_wp       <= r_wp + 1'b1;
            end
            if (w_load) begin
                r_rp    <= r_rp + 1'b1;
                r_valid <= 1'b1;
                r_res   <= w_res;
                r_dz    <= w_dz;
                r_ill   <= w_ill;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_load);
        end
    end
endmodule

// File: tb/tb_arith_issue_q.sv
// tb_arith_issue_q: directed and randomized checks of arith_issue_q against a queue-based reference model
module tb_arith_issue_q;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, out_dz, out_ill;
    logic [3:0]   in_op;
    logic [W-1:0] in_a, in_b, out_res;
    logic [2:0]   count;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    arith_issue_q #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_dz(out_dz),
        .out_ill(out_ill), .count(count)
    );

    // {ill, dz, res} computed with plain integer arithmetic
    function automatic logic [9:0] ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r = 0;
        logic dz = 1'b0;
        logic ill = 1'b0;
        logic [31:0] rv;
        case (op)
            0, 1: r = ua + ub;
            2, 3: r = ua - ub;
            4:    r = ua * ub;
            5:    r = sa * sb;
            6:    if (ub == 0) begin dz = 1; r = 255; end else r = ua / ub;
            7:    if (ub == 0) begin dz = 1; r = 255; end else r = sa / sb;
            8:    if (ub == 0) begin dz = 1; r = ua;  end else r = ua % ub;
            9:    if (ub == 0) begin dz = 1; r = ua;  end else r = sa % sb;
            default: ill = 1;
        endcase
        rv = r;
        return {ill, dz, rv[7:0]};
    endfunction

    task automatic apply_reset();
        in_valid = 0; out_ready = 0; in_op = 0; in_a = 0; in_b = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; out_ready = 0; in_op = 0; in_a = 0; in_b = 0;
        #2;
        n_checks++;
        if ({out_valid, out_res, out_dz, out_ill, count, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got v=%b res=%h dz=%b ill=%b cnt=%0d rdy=%b want 0/00/0/0/0/1",
                     out_valid, out_res, out_dz, out_ill, count, in_ready);
        end
        @(posedge clk); #1;
        reset = 0;
        out_ready = 1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle got v=%b cnt=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        out_ready = 1;
        in_valid = 1; in_op = 0; in_a = 8'd200; in_b = 8'd100;
        @(posedge clk); #1;
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL latency_first_edge got v=%b cnt=%0d want 0/1", out_valid, count);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_res, out_dz, out_ill, count} !== {1'b1, 8'h2C, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL latency_result got v=%b res=%h dz=%b ill=%b cnt=%0d want 1/2c/0/0/0",
                     out_valid, out_res, out_dz, out_ill, count);
        end
    endtask

    task automatic test_ops();
        logic [3:0] t_op  [8] = '{4'd5, 4'd7, 4'd9, 4'd7, 4'd6, 4'd8, 4'd12, 4'd9};
        logic [7:0] t_a   [8] = '{8'hFD, 8'hF9, 8'hF9, 8'h80, 8'h09, 8'h09, 8'h03, 8'h80};
        logic [7:0] t_b   [8] = '{8'h05, 8'h02, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h04, 8'hFF};
        logic [9:0] t_exp [8] = '{10'h0F1, 10'h0FD, 10'h0FF, 10'h080, 10'h1FF, 10'h109, 10'h200, 10'h000};
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_op = t_op[i]; in_a = t_a[i]; in_b = t_b[i];
            @(posedge clk); #1;
            in_valid = 0;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || {out_ill, out_dz, out_res} !== t_exp[i]) begin
                n_fail++;
                $display("FAIL op_%0d op=%0d a=%h b=%h got v=%b ill=%b dz=%b res=%h want ill/dz/res=%h",
                         i, t_op[i], t_a[i], t_b[i], out_valid, out_ill, out_dz, out_res, t_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ec [6] = '{1, 1, 2, 3, 4, 4};
        apply_reset();
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_op = 0; in_a = 8'(i * 10 + 1); in_b = 8'd1;
            @(posedge clk); #1;
            n_checks++;
            if (count !== 3'(ec[i]) || in_ready !== (i < 4)) begin
                n_fail++;
                $display("FAIL bp_fill_%0d got cnt=%0d rdy=%b want %0d/%b", i, count, in_ready, ec[i], i < 4);
            end
            if (i >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_res !== 8'd2) begin
                    n_fail++;
                    $display("FAIL bp_hold_%0d got v=%b res=%h want 1/02", i, out_valid, out_res);
                end
            end
        end
        in_valid = 0;
        out_ready = 1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_res !== 8'((j + 1) * 10 + 2)) begin
                n_fail++;
                $display("FAIL bp_drain_%0d got v=%b res=%h want 1/%h", j, out_valid, out_res, 8'((j + 1) * 10 + 2));
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_res !== 8'd42) begin
            n_fail++;
            $display("FAIL bp_empty got v=%b cnt=%0d res=%h want 0/0/2a", out_valid, count, out_res);
        end
    endtask

    task automatic test_full_pop();
        apply_reset();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_op = 0; in_a = 8'(i); in_b = 8'd1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_res !== 8'd1) begin
            n_fail++;
            $display("FAIL full_state got cnt=%0d rdy=%b res=%h want 4/0/01", count, in_ready, out_res);
        end
        in_valid = 1; in_a = 8'd99; out_ready = 1;
        @(posedge clk); #1;
        n_checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_res !== 8'd2) begin
            n_fail++;
            $display("FAIL full_pop got cnt=%0d rdy=%b res=%h want 3/1/02", count, in_ready, out_res);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 0; out_ready = 0;
        #2;
        reset = 1;
        #1;
        n_checks++;
        if ({out_valid, out_res, out_dz, out_ill, count, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async got v=%b res=%h dz=%b ill=%b cnt=%0d rdy=%b want 0/00/0/0/0/1",
                     out_valid, out_res, out_dz, out_ill, count, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_stale_%0d got v=%b cnt=%0d want 0/0", i, out_valid, count);
            end
        end
    endtask

    task automatic test_random(input int n, input int pv, input int pr);
        logic [9:0] q[$];
        logic       mv = 1'b0;
        logic [9:0] mout = '0;
        logic       push, load;
        logic [7:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        apply_reset();
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom % 100) < pv;
            out_ready = ($urandom % 100) < pr;
            in_op     = 4'($urandom_range(0, 15));
            in_a      = ($urandom % 3 == 0) ? corners[$urandom % 5] : 8'($urandom);
            in_b      = ($urandom % 4 == 0) ? corners[$urandom % 5] : 8'($urandom);
            n_checks++;
            if (count !== 3'(q.size()) || in_ready !== (q.size() != D)) begin
                n_fail++;
                $display("FAIL rand_occ_%0d got cnt=%0d rdy=%b want %0d/%b", i, count, in_ready, q.size(), q.size() != D);
            end
            n_checks++;
            if (out_valid !== mv || {out_ill, out_dz, out_res} !== mout) begin
                n_fail++;
                $display("FAIL rand_out_%0d got v=%b ill/dz/res=%h want %b/%h", i, out_valid, {out_ill, out_dz, out_res}, mv, mout);
            end
            push = in_valid && (q.size() < D);
            load = (q.size() != 0) && (!mv || out_ready);
            if (load) begin
                mout = q.pop_front();
                mv = 1'b1;
            end else if (mv && out_ready) begin
                mv = 1'b0;
            end
            if (push) q.push_back(ref_model(in_op, in_a, in_b));
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    task automatic test_back_to_back();
        test_random(24, 100, 100);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        test_random(400, 60, 60);
        test_random(300, 80, 30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
